spi_nor_flash_sync_model: RTL

Parametrised SPI NOR flash behavioural model, clocked by a system clock instead of SCLK. Oversamples the master's SCLK/CS_N/DQ, decodes the standard command set, and models 3/4-byte addressing, AND-only programming, timed erase/program busy (WIP), and optional quad output read. Sits on the bench behind axi_spi_master as the flash device.

---
 rtl/spi_nor_flash_sync_model_if.sv | 12 +
 rtl/spi_nor_flash_sync_model.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_nor_flash_sync_model_if.sv
// SPI flash pin bundle between a bus master and the oversampled flash model.
interface spi_nor_flash_sync_model_if;
  logic       sclk;
  logic       cs_n;
  logic [3:0] dq_i;
  logic [3:0] dq_o;
  logic [3:0] dq_oe;
  logic       wip;

  modport master (output sclk, cs_n, dq_i, input dq_o, dq_oe, wip);
  modport slave  (input sclk, cs_n, dq_i, output dq_o, dq_oe, wip);
endinterface

// File: rtl/spi_nor_flash_sync_model.sv
// SPI NOR flash model clocked by clk, oversampling SCLK/CS_N/DQ (mode 0).
// Define QSPI_QUAD_OUT_READ_EN to accept 6Bh quad output read.
module spi_nor_flash_sync_model #(
  parameter int unsigned MEM_BYTES        = 65536,
  parameter int unsigned PAGE_SIZE        = 256,
  parameter int unsigned SECTOR_SIZE      = 4096,
  parameter int unsigned PROG_BUSY_CYCLES = 64,
  parameter int unsigned FAST_READ_DUMMY  = 8,
  parameter bit          ADDR4_DEFAULT    = 1'b0,
  parameter logic [7:0]  MFR_ID           = 8'h20,
  parameter logic [15:0] DEVICE_ID        = 16'hBA19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_nor_flash_sync_model_if.slave bus
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [AW-1:0] PM = AW'(PAGE_SIZE - 1);
  localparam logic [AW-1:0] SM = AW'(SECTOR_SIZE - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA_OUT, DATA_IN, DONE, BUSY} state_t;

  state_t state, state_n;

  logic [1:0] sclk_s, cs_s, mosi_s;
  logic       sclk_q;
  logic       cs_hi, rise, fall, mosi;

  logic [6:0]    sh;
  logic [7:0]    cmd, cmd_full;
  logic [AW-2:0] addr_sh;
  logic [AW-1:0] addr_full, rd_addr, wr_addr, er_base;
  logic [7:0]    bit_cnt;
  logic [7:0]    out_sh, rd_byte;
  logic [2:0]    out_cnt;
  logic          need_load, wrote;
  logic          wel, addr4, rst_en;
  logic          busy, busy_er;
  logic [31:0]   busy_cnt, busy_len;
  logic [3:0]    dq_o_r;
  logic          quad_op, quad_rd;
  logic          addr_last;

  logic [7:0]    mem [MEM_BYTES] = '{default: 8'hFF};
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;

  logic unused_dq;
  assign unused_dq = ^bus.dq_i[3:1];

  // Equal-depth synchronisers keep MOSI aligned with the detected SCLK edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= 2'b11;
      mosi_s <= '0;
      sclk_q <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], bus.sclk};
      cs_s   <= {cs_s[0], bus.cs_n};
      mosi_s <= {mosi_s[0], bus.dq_i[0]};
      sclk_q <= sclk_s[1];
    end
  end

  assign cs_hi     = cs_s[1];
  assign mosi      = mosi_s[1];
  assign rise      = sclk_s[1] & ~sclk_q & ~cs_hi;
  assign fall      = ~sclk_s[1] & sclk_q & ~cs_hi;
  assign cmd_full  = {sh, mosi};
  assign addr_full = {addr_sh, mosi};
  assign addr_last = rise && (bit_cnt == (addr4 ? 8'd31 : 8'd23));
  assign busy_len  = busy_er ? 32'(SECTOR_SIZE) : 32'(PROG_BUSY_CYCLES);

`ifdef QSPI_QUAD_OUT_READ_EN
  assign quad_op = (cmd_full == 8'h6B);
  assign quad_rd = (cmd == 8'h6B);
`else
  assign quad_op = 1'b0;
  assign quad_rd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_hi) state_n = IDLE;
    else begin
      case (state)
        IDLE: state_n = CMD;
        CMD: if (rise && bit_cnt == 8'd7) begin
          if (busy && cmd_full != 8'h05) state_n = DONE;
          else if (cmd_full == 8'h03 || cmd_full == 8'h0B || quad_op) state_n = ADDR;
          else if (cmd_full == 8'h02 || cmd_full == 8'h20) state_n = wel ? ADDR : DONE;
          else if (cmd_full == 8'h9F || cmd_full == 8'h05) state_n = DATA_OUT;
          else state_n = DONE;
        end
        ADDR: if (addr_last) begin
          case (cmd)
            8'h03:   state_n = DATA_OUT;
            8'h02:   state_n = DATA_IN;
            8'h20:   state_n = BUSY;
            default: state_n = (FAST_READ_DUMMY == 0) ? DATA_OUT : DUMMY;
          endcase
        end
        DUMMY: if (rise && bit_cnt == 8'(FAST_READ_DUMMY - 1)) state_n = DATA_OUT;
        default: state_n = state;
      endcase
    end
  end

  // Next outgoing byte; status is resampled each time a byte is loaded.
  always_comb begin
    rd_byte = mem[rd_addr];
    if (cmd == 8'h05) rd_byte = {6'b0, wel, busy};
    else if (cmd == 8'h9F) begin
      case (rd_addr)
        AW'(0):  rd_byte = MFR_ID;
        AW'(1):  rd_byte = DEVICE_ID[15:8];
        AW'(2):  rd_byte = DEVICE_ID[7:0];
        default: rd_byte = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      cmd       <= '0;
      addr_sh   <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      er_base   <= '0;
      bit_cnt   <= '0;
      out_sh    <= '0;
      out_cnt   <= '0;
      need_load <= 1'b0;
      wrote     <= 1'b0;
      wel       <= 1'b0;
      addr4     <= ADDR4_DEFAULT;
      rst_en    <= 1'b0;
      busy      <= 1'b0;
      busy_er   <= 1'b0;
      busy_cnt  <= '0;
      dq_o_r    <= '0;
    end else begin
      if (busy) begin
        busy_cnt <= busy_cnt + 32'd1;
        if (busy_cnt == busy_len - 32'd1) busy <= 1'b0;
      end
      if (cs_hi) begin
        sh        <= '0;
        addr_sh   <= '0;
        bit_cnt   <= '0;
        out_cnt   <= '0;
        need_load <= 1'b0;
        dq_o_r    <= '0;
        wrote     <= 1'b0;
        // Frame end commits an armed erase or a program that wrote data.
        if (state == BUSY || (state == DATA_IN && wrote)) begin
          busy     <= 1'b1;
          busy_er  <= (state == BUSY);
          busy_cnt <= '0;
          wel      <= 1'b0;
        end
      end else begin
        if (state != DATA_OUT && state_n == DATA_OUT) need_load <= 1'b1;
        case (state)
          CMD: if (rise) begin
            sh      <= cmd_full[6:0];
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == 8'd7) begin
              bit_cnt <= '0;
              cmd     <= cmd_full;
              rd_addr <= '0;
              rst_en  <= 1'b0;
              if (!busy) begin
                case (cmd_full)
                  8'h06: wel    <= 1'b1;
                  8'h04: wel    <= 1'b0;
                  8'hB7: addr4  <= 1'b1;
                  8'hE9: addr4  <= 1'b0;
                  8'h66: rst_en <= 1'b1;
                  8'h99: if (rst_en) begin
                    wel   <= 1'b0;
                    addr4 <= ADDR4_DEFAULT;
                  end
                  default: ;
                endcase
              end
            end
          end
          ADDR: if (rise) begin
            addr_sh <= addr_full[AW-2:0];
            bit_cnt <= bit_cnt + 8'd1;
            if (addr_last) begin
              bit_cnt <= '0;
              rd_addr <= addr_full;
              wr_addr <= addr_full;
              er_base <= addr_full & ~SM;
            end
          end
          DUMMY: if (rise) bit_cnt <= bit_cnt + 8'd1;
          DATA_IN: if (rise) begin
            sh      <= cmd_full[6:0];
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == 8'd7) begin
              bit_cnt <= '0;
              wrote   <= 1'b1;
              wr_addr <= (wr_addr & ~PM) | ((wr_addr + AW'(1)) & PM);
            end
          end
          DATA_OUT: begin
            if (need_load) begin
              out_sh    <= rd_byte;
              out_cnt   <= '0;
              need_load <= 1'b0;
              if (!(cmd == 8'h9F && rd_addr == AW'(3))) rd_addr <= rd_addr + AW'(1);
            end else if (fall) begin
              out_cnt <= out_cnt + 3'd1;
              if (quad_rd) begin
                dq_o_r <= out_sh[7:4];
                out_sh <= {out_sh[3:0], 4'b0};
                if (out_cnt == 3'd1) need_load <= 1'b1;
              end else begin
                dq_o_r <= {2'b0, out_sh[7], 1'b0};
                out_sh <= {out_sh[6:0], 1'b0};
                if (out_cnt == 3'd7) need_load <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Erase sweeps one byte per clk; programming only clears bits.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = cmd_full & mem[wr_addr];
    if (busy && busy_er) begin
      mem_we = 1'b1;
      mem_wa = er_base | busy_cnt[AW-1:0];
      mem_wd = 8'hFF;
    end else if (state == DATA_IN && rise && bit_cnt == 8'd7) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign bus.dq_o  = dq_o_r;
  assign bus.dq_oe = (state == DATA_OUT && !cs_hi) ? (quad_rd ? 4'hF : 4'b0010) : 4'b0000;
  assign bus.wip   = busy;
endmodule
